// File: rtl/vedic_mul_seq.sv
// Sequential multiplier built around one 4x4 Vedic (urdhva-tiryagbhyam) digit product.
// Each CALC cycle multiplies one nibble pair and accumulates it at the right weight.
// Signed operands are handled as magnitudes, and the sign is applied once at the end.
module vedic_mul_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned D  = WIDTH / 4;
    localparam int unsigned IW = (D > 1) ? $clog2(D) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   amag_q, amag_d;
    logic [WIDTH-1:0]   bmag_q, bmag_d;
    logic               neg_q, neg_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [IW-1:0]      i_q, i_d;
    logic [IW-1:0]      j_q, j_d;
    logic [PW-1:0]      product_d;
    logic               out_valid_d;
    logic               in_ready_d;
    logic               busy_d;

    logic [3:0]         a_dig;
    logic [3:0]         b_dig;
    logic [7:0]         pp;
    logic [IW:0]        ij_sum;
    logic [PW-1:0]      acc_sum;

    // 2x2 Vedic cell: vertical and crosswise products with two half adders
    function automatic logic [3:0] vedic2(input logic [1:0] x, input logic [1:0] y);
        logic       c0;
        logic       c1;
        logic [3:0] r;
        r[0]      = x[0] & y[0];
        {c0, r[1]} = {1'b0, x[1] & y[0]} + {1'b0, x[0] & y[1]};
        {c1, r[2]} = {1'b0, x[1] & y[1]} + {1'b0, c0};
        r[3]      = c1;
        return r;
    endfunction

    // 4x4 Vedic multiplier composed from four 2x2 cells
    function automatic logic [7:0] vedic4(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] q2;
        logic [3:0] q3;
        q0 = vedic2(x[1:0], y[1:0]);
        q1 = vedic2(x[3:2], y[1:0]);
        q2 = vedic2(x[1:0], y[3:2]);
        q3 = vedic2(x[3:2], y[3:2]);
        return {4'b0000, q0} + {2'b00, q1, 2'b00} + {2'b00, q2, 2'b00} + {q3, 4'b0000};
    endfunction

    // Current nibble pair product, shifted to weight 16^(i+j) and added to the accumulator
    always_comb begin
        a_dig   = amag_q[{i_q, 2'b00} +: 4];
        b_dig   = bmag_q[{j_q, 2'b00} +: 4];
        pp      = vedic4(a_dig, b_dig);
        ij_sum  = {1'b0, i_q} + {1'b0, j_q};
        acc_sum = acc_q + (PW'(pp) << {ij_sum, 2'b00});
    end

    // Next-state, datapath and output decode
    always_comb begin
        state_d     = state_q;
        amag_d      = amag_q;
        bmag_d      = bmag_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        i_d         = i_q;
        j_d         = j_q;
        product_d   = product;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b0;
        busy_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (is_signed) begin
                        amag_d = a[WIDTH-1] ? WIDTH'(~a + WIDTH'(1)) : a;
                        bmag_d = b[WIDTH-1] ? WIDTH'(~b + WIDTH'(1)) : b;
                        neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
                    end else begin
                        amag_d = a;
                        bmag_d = b;
                        neg_d  = 1'b0;
                    end
                    acc_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_sum;
                if (j_q == IW'(D - 1)) begin
                    j_d = '0;
                    if (i_q == IW'(D - 1)) begin
                        product_d = neg_q ? PW'(~acc_sum + PW'(1)) : acc_sum;
                        state_d   = DONE;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    j_d = j_q + IW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            amag_q    <= '0;
            bmag_q    <= '0;
            neg_q     <= 1'b0;
            acc_q     <= '0;
            i_q       <= '0;
            j_q       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            amag_q    <= amag_d;
            bmag_q    <= bmag_d;
            neg_q     <= neg_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            j_q       <= j_d;
            product   <= product_d;
            out_valid <= out_valid_d;
            in_ready  <= in_ready_d;
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Testbench for vedic_mul_seq: a WIDTH=8 and a WIDTH=16 instance checked against
// a transaction-level model (integer multiply plus a cycle count), with literal expectations.
module tb_vedic_mul_seq;

    logic        clk;
    logic        rst_n;

    logic        iv   [2];
    logic [15:0] av   [2];
    logic [15:0] bv   [2];
    logic        sv   [2];
    logic        ordy [2];

    logic        ir   [2];
    logic        ov   [2];
    logic        bz   [2];
    logic [15:0] p8;
    logic [31:0] p16;
    logic [31:0] pr   [2];

    assign pr[0] = {16'h0000, p8};
    assign pr[1] = p16;

    int n_cmp = 0;
    int n_bad = 0;

    vedic_mul_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][7:0]), .b(bv[0][7:0]), .is_signed(sv[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]),
        .product(p8), .busy(bz[0])
    );

    vedic_mul_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .is_signed(sv[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]),
        .product(p16), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s [w%0d] t=%0t got %h expected %h", nm, (k == 0) ? 8 : 16, $time, got, exp);
        end
    endtask

    // Reference product from plain integer arithmetic
    function automatic logic [31:0] ref_prod(input int w, input logic [15:0] x, input logic [15:0] y,
                                             input logic s);
        logic [15:0] mask;
        logic [15:0] xm;
        logic [15:0] ym;
        longint      sx;
        longint      sy;
        logic [63:0] p;
        mask = (w == 16) ? 16'hFFFF : 16'h00FF;
        xm   = x & mask;
        ym   = y & mask;
        sx   = longint'(xm);
        sy   = longint'(ym);
        if (s && xm[w-1]) sx = sx - (longint'(1) << w);
        if (s && ym[w-1]) sy = sy - (longint'(1) << w);
        p = 64'(sx * sy);
        return (w == 16) ? p[31:0] : {16'h0000, p[15:0]};
    endfunction

    // Transaction model: accept in idle, result visible after D*D cycles, cleared by handshake
    logic        m_busy [2];
    logic        m_ov   [2];
    int          m_cnt  [2];
    logic [31:0] m_exp  [2];
    logic [31:0] m_prod [2];

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] <= 1'b0;
                m_ov[k]   <= 1'b0;
                m_cnt[k]  <= 0;
                m_exp[k]  <= 32'h0;
                m_prod[k] <= 32'h0;
            end else if (!m_busy[k]) begin
                if (iv[k]) begin
                    m_busy[k] <= 1'b1;
                    m_cnt[k]  <= 0;
                    m_exp[k]  <= ref_prod((k == 0) ? 8 : 16, av[k], bv[k], sv[k]);
                end
            end else if (!m_ov[k]) begin
                m_cnt[k] <= m_cnt[k] + 1;
                if (m_cnt[k] + 1 == ((k == 0) ? 4 : 16)) begin
                    m_ov[k]   <= 1'b1;
                    m_prod[k] <= m_exp[k];
                end
            end else if (ordy[k]) begin
                m_ov[k]   <= 1'b0;
                m_busy[k] <= 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            chk("in_ready", k, 32'(ir[k]), 32'(!m_busy[k]));
            chk("out_valid", k, 32'(ov[k]), 32'(m_ov[k]));
            chk("busy", k, 32'(bz[k]), 32'(m_busy[k]));
            chk("product", k, pr[k], m_prod[k]);
        end
    end

    // One directed transaction with literal expected product
    task automatic txn(input int k, input logic [15:0] ta, input logic [15:0] tb_v, input logic ts,
                       input logic [31:0] lit, input int stall, input bit perturb);
        int guard;
        int lat;
        int dd;
        dd    = (k == 0) ? 4 : 16;
        guard = 0;
        @(negedge clk);
        while (!ir[k] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_wait", k, 32'(ir[k]), 32'd1);
        av[k]   = ta;
        bv[k]   = tb_v;
        sv[k]   = ts;
        iv[k]   = 1'b1;
        ordy[k] = (stall == 0);
        @(negedge clk);
        iv[k] = 1'b0;
        if (perturb) begin
            av[k] = ~ta;
            bv[k] = 16'h003C;
            sv[k] = ~ts;
        end
        chk("model_pin", k, m_exp[k], lit);
        chk("ready_low", k, 32'(ir[k]), 32'd0);
        lat = 1;
        while (!ov[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", k, 32'(lat), 32'(dd + 1));
        chk("result", k, pr[k], lit);
        for (int s = 0; s < stall; s++) begin
            iv[k] = 1'b1;
            av[k] = ~ta;
            @(negedge clk);
            chk("stall_prod", k, pr[k], lit);
            chk("stall_valid", k, 32'(ov[k]), 32'd1);
            chk("stall_ready", k, 32'(ir[k]), 32'd0);
        end
        iv[k]   = 1'b0;
        ordy[k] = 1'b1;
        @(negedge clk);
        chk("post_valid", k, 32'(ov[k]), 32'd0);
        chk("post_ready", k, 32'(ir[k]), 32'd1);
        chk("post_prod", k, pr[k], lit);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k]   = 1'b0;
            av[k]   = 16'h0;
            bv[k]   = 16'h0;
            sv[k]   = 1'b0;
            ordy[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        chk("rst_ready", 0, 32'(ir[0]), 32'd1);
        chk("rst_valid", 0, 32'(ov[0]), 32'd0);
        chk("rst_prod", 0, pr[0], 32'h0);
        chk("rst_busy", 0, 32'(bz[0]), 32'd0);
        #2 rst_n = 1'b1;

        txn(0, 16'h00FF, 16'h00FF, 1'b0, 32'h0000FE01, 0, 1'b0);
        txn(0, 16'h0080, 16'h0080, 1'b1, 32'h00004000, 0, 1'b0);
        txn(0, 16'h0080, 16'h007F, 1'b1, 32'h0000C080, 0, 1'b0);
        txn(0, 16'h0080, 16'h007F, 1'b0, 32'h00003F80, 0, 1'b0);
        txn(0, 16'h0012, 16'h0034, 1'b0, 32'h000003A8, 3, 1'b0);
        txn(0, 16'h0005, 16'h0007, 1'b1, 32'h00000023, 0, 1'b1);

        // Reset during the second CALC cycle aborts the transaction
        @(negedge clk);
        av[0] = 16'h0011;
        bv[0] = 16'h0022;
        sv[0] = 1'b0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_valid", 0, 32'(ov[0]), 32'd0);
        chk("abort_prod", 0, pr[0], 32'h0);
        chk("abort_ready", 0, 32'(ir[0]), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("no_stale", 0, 32'(ov[0]), 32'd0);

        txn(0, 16'h0000, 16'h0080, 1'b1, 32'h00000000, 0, 1'b0);
        txn(0, 16'h00FF, 16'h0001, 1'b1, 32'h0000FFFF, 0, 1'b0);
        txn(0, 16'h007F, 16'h007F, 1'b1, 32'h00003F01, 1, 1'b0);

        txn(1, 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, 1'b0);
        txn(1, 16'h8000, 16'h0002, 1'b1, 32'hFFFF0000, 2, 1'b0);

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
